// File: rtl/tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tff_count_ctrl
//
// Sequencing controller for a WIDTH-bit bank of T flip-flops. It drives the
// bank's toggle enables and synchronous clear, using the bank's Q outputs as
// feedback, so that the bank counts 0..limit once (one-shot timer) or
// repeatedly (periodic divider).
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   start    start request, honoured only in IDLE
//   stop     abort request, honoured in CLEAR and RUN
//   mode     0 = one-shot, 1 = periodic (latched with start)
//   limit    terminal count (latched with start)
//   q_in     current Q of the TFF bank
//   t_out    toggle enables to the bank's T inputs
//   clr_out  synchronous clear to the bank
//   busy     high in CLEAR and RUN
//   done     one-cycle pulse at one-shot completion
//   wrap     one-cycle pulse after each periodic terminal count
// ---------------------------------------------------------------------------
module tff_count_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             clr_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] limit_r;
  logic             mode_r;
  logic             wrap_r;
  logic             wrap_next_s;
  logic             latch_s;
  logic [WIDTH-1:0] t_s;
  logic             clr_s;
  logic             match_s;

  // Toggle pattern that advances a T-flip-flop bank by one: bit i toggles
  // when every lower bit is 1 (bit 0 always toggles).
  function automatic logic [WIDTH-1:0] inc_toggles(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & q[i-1];
    end
    return t;
  endfunction

  assign match_s = (q_in == limit_r);

  // Next-state and bank-control decode; in RUN, stop outranks match,
  // which outranks counting.
  always_comb begin
    state_next_s = state_r;
    t_s          = {WIDTH{1'b0}};
    clr_s        = 1'b0;
    wrap_next_s  = 1'b0;
    latch_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          latch_s      = 1'b1;
          state_next_s = CLEAR;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLEAR: begin
        clr_s = 1'b1;
        if (stop) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next_s = IDLE;
        end else if (match_s) begin
          if (mode_r) begin
            // Periodic: clear the bank back to 0 and flag the wrap, which
            // shows up in the cycle where the bank reads 0 again.
            clr_s        = 1'b1;
            wrap_next_s  = 1'b1;
            state_next_s = RUN;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          t_s          = inc_toggles(q_in);
          state_next_s = RUN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, latched operating parameters and wrap pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      limit_r <= {WIDTH{1'b0}};
      mode_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      wrap_r  <= wrap_next_s;
      if (latch_s) begin
        limit_r <= limit;
        mode_r  <= mode;
      end else begin
        limit_r <= limit_r;
        mode_r  <= mode_r;
      end
    end
  end

  // Outputs are forced low while reset is asserted so the bank is never
  // disturbed during reset, whatever state the register held before it.
  assign t_out   = reset ? {WIDTH{1'b0}} : t_s;
  assign clr_out = reset ? 1'b0 : clr_s;
  assign busy    = reset ? 1'b0 : ((state_r == CLEAR) || (state_r == RUN));
  assign done    = reset ? 1'b0 : (state_r == DONE);
  assign wrap    = reset ? 1'b0 : wrap_r;

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a WIDTH-bit bank of T flip-flops. It drives the bank's toggle enables and synchronous clear so that the bank counts 0..LIMIT, either once or repeatedly. It uses the bank's Q outputs as feedback. It sits between a start/stop control source and the TFF bank, turning the bank into a programmable one-shot timer or periodic divider.

## Interface
Parameters:
- WIDTH, 8, width of the TFF bank, limit and toggle vector (>= 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  start request; sampled only in IDLE
- stop  input  1  abort request; sampled in CLEAR and RUN
- mode  input  1  0 = one-shot, 1 = periodic; latched with start
- limit  input  WIDTH  terminal count; latched with start
- q_in  input  WIDTH  current Q of the TFF bank (feedback)
- t_out  output  WIDTH  toggle enables to the bank's T inputs
- clr_out  output  1  synchronous clear to the bank (bank Q = 0 after the edge)
- busy  output  1  high in CLEAR and RUN
- done  output  1  one-cycle pulse at one-shot completion
- wrap  output  1  one-cycle pulse after each periodic terminal count

## Operation
- States: IDLE, CLEAR, RUN, DONE, held in a registered state register.
- Reset: state = IDLE, latched limit/mode = 0, wrap register = 0.
  - All outputs are 0 while reset is high and in the cycle after.
- IDLE:
  - t_out = 0, clr_out = 0.
  - start = 1 → latch limit and mode → CLEAR.
- CLEAR:
  - clr_out = 1, t_out = 0.
  - Next state is RUN, or IDLE if stop = 1. clr_out is still 1 in the cycle where stop is taken.
- RUN:
  - Match = (q_in == latched limit).
  - No match: t_out[0] = 1 and t_out[i] = &q_in[i-1:0], which is the increment pattern, so the bank goes to q_in+1 on the next edge.
  - Match in one-shot mode: t_out = 0, then go to DONE.
  - Match in periodic mode: clr_out = 1, t_out = 0, stay in RUN, and set the wrap register.
- DONE: done = 1, t_out = 0, then go to IDLE unconditionally. start is ignored in DONE.
- Output derivation:
  - t_out and clr_out are combinational from the registered state, the latched limit/mode and q_in.
  - busy = state in {CLEAR, RUN}; done = (state == DONE); wrap is a register.
- Priority in RUN: stop > match > count.
  - stop → IDLE next edge, t_out = 0 and clr_out = 0 in that cycle, no done or wrap.
- start outside IDLE is ignored; limit and mode changes after latching have no effect.
- Boundary cases:
  - limit = 0, one-shot: match on the first RUN cycle, so done follows immediately.
  - limit = 0, periodic: clr_out is held every RUN cycle, and wrap is high every cycle from the second RUN cycle onward.
  - limit = 2^WIDTH−1: the bank counts through all codes, with no overflow before the match.
  - q_in > limit in RUN (bank corrupted externally): counting continues modulo 2^WIDTH until a match occurs. No error flag.
- Reset mid-operation: return to IDLE with outputs 0 after the edge. The bank contents are not cleared by this block.

## Timing
- Start at edge 0 (start sampled high in IDLE):
  - After edge 1: CLEAR.
  - After edge 2: RUN, q_in = 0.
  - After edge 2+k: q_in = k.
- One-shot with limit L:
  - Match cycle follows edge 2+L.
  - DONE (done = 1) follows edge 3+L.
  - IDLE follows edge 4+L.
  - Start-to-done latency is 3+L cycles.
- Periodic with limit L:
  - q_in sequence 0,1,..,L,0,1,.. with period L+1 cycles.
  - wrap is high in the cycle where q_in = 0 after each match, one cycle after the match cycle.
- busy rises after edge 1 and falls on the edge that leaves RUN (entry to DONE or IDLE).
- A new start is accepted in the first IDLE cycle after DONE, so back-to-back one-shots are 4+L cycles apart.

## Test plan
- Reset then idle: hold reset 2 cycles, start = 0 → t_out = 0, clr_out = 0, busy = 0, done = 0, wrap = 0.
- One-shot, WIDTH = 4, limit = 5, with a behavioural TFF bank → bank counts 0..5 and holds 5; done pulses exactly once, 8 cycles after start; busy is high for 7 cycles.
- Periodic, limit = 3 → q_in sequence 0,1,2,3,0,1,2,3 ...; wrap pulses every 4 cycles, coincident with q_in = 0; done never asserts.
- Edge limits, one-shot:
  - limit = 0 → done 3 cycles after start; t_out never nonzero.
  - limit = 15 (WIDTH = 4) → done 18 cycles after start; t_out = 4'b1111 on the 7→8 and 15 transitions never occurs at 15 (match).
- stop asserted when q_in = 2 (limit = 9) → IDLE next cycle, t_out = 0, no done; bank holds 2. A following start runs CLEAR then counts from 0.
- Reset asserted mid-RUN at q_in = 4 → all outputs 0 the next cycle, state IDLE. start during DONE is ignored; start held high through DONE relaunches only from IDLE.
